// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Optional feature macro: SERIAL_SUBTRACTOR_SIGNED_OVF_EN (adds the signed overflow flag).
package serial_subtractor_pkg;

    // Operand widths the datapath is designed for.
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    // Control states: waiting for a request, shifting bits, presenting the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter width; it only needs to reach WIDTH-1, and it never shrinks below one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor_d.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor_d (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit is the parity of the three inputs; a borrow is needed
    // when b exceeds a, or when they are equal and a borrow is coming in.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, LSB first, one bit per clock through a
// single full-subtractor cell with a registered borrow.
// Optional feature macro: SERIAL_SUBTRACTOR_SIGNED_OVF_EN adds the ovf output
// (two's-complement signed overflow), computed from dedicated MSB capture flops.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             busy,
    output logic             done
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             bin;
    logic [CNT_W-1:0] count;
    logic             d_bit;
    logic             bout_bit;
    logic [WIDTH-1:0] res_next;

`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    // The one arithmetic cell, always looking at the current LSBs and the stored borrow.
    full_subtractor_d u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (bin),
        .d    (d_bit),
        .bout (bout_bit)
    );

    // Result register after this edge's bit is shifted in at the MSB end;
    // after WIDTH shifts the first bit computed sits at bit 0.
    always_comb begin
        res_next = {d_bit, res_sh[WIDTH-1:1]};
    end

    // Control FSM and datapath; diff/borrow only update on the final bit, so
    // the visible result stays stable for the whole of the next operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            bin    <= 1'b0;
            count  <= '0;
            diff   <= '0;
            borrow <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        res_sh <= '0;
                        bin    <= 1'b0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
`endif
                    end
                end

                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    bin    <= bout_bit;
                    count  <= count + 1'b1;
                    if (count == LAST_BIT) begin
                        diff   <= res_next;
                        borrow <= bout_bit;
                        done   <= 1'b1;
                        state  <= DONE;
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
                        // The last bit computed is the result MSB.
                        ovf    <= (a_msb != b_msb) && (d_bit != a_msb);
`endif
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed cases plus
// random operands checked against plain modular arithmetic.
// Honours SERIAL_SUBTRACTOR_SIGNED_OVF_EN when the design is built with it.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow;
    logic         busy;
    logic         done;
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
    logic         ovf;
`endif

    int assertCount = 0;
    int failCount   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .diff   (diff),
        .borrow (borrow),
        .busy   (busy),
        .done   (done)
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: unsigned modular difference, borrow iff a < b, signed overflow
    // iff the true signed difference falls outside the W-bit signed range.
    function automatic logic [W-1:0] refDiff(input logic [W-1:0] av, input logic [W-1:0] bv);
        int unsigned r;
        r = (int'(av) + (1 << W) - int'(bv)) % (1 << W);
        return W'(r);
    endfunction

    function automatic logic refOvf(input logic [W-1:0] av, input logic [W-1:0] bv);
        int sd;
        sd = int'($signed(av)) - int'($signed(bv));
        return (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
    endfunction

    // Run one operation; optionally re-pulse start with other operands mid-run
    // to confirm a request while busy is dropped.
    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input bit reStart);
        logic [W-1:0] prevDiff;
        logic         prevBorrow;
        int           k;
        int           busyCycles;

        @(negedge clk);
        prevDiff   = diff;
        prevBorrow = borrow;
        a     = av;
        b     = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);

        k = 0;
        busyCycles = 0;
        while (!done && k < 4 * W) begin
            if (busy) busyCycles++;
            if (k == W / 2) begin
                checkOutput("hold_diff", 32'(diff), 32'(prevDiff));
                checkOutput("hold_borrow", 32'(borrow), 32'(prevBorrow));
            end
            if (reStart && k == 3) begin
                a     = 8'hFF;
                b     = 8'h00;
                start = 1'b1;
            end
            if (reStart && k == 4) start = 1'b0;
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        if (busy) busyCycles++;

        checkOutput("done_seen", 32'(done), 32'd1);
        checkOutput("latency", 32'(k), 32'(W));
        checkOutput("busy_cycles", 32'(busyCycles), 32'(W + 1));
        checkOutput("diff", 32'(diff), 32'(refDiff(av, bv)));
        checkOutput("borrow", 32'(borrow), 32'(av < bv));
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
        checkOutput("ovf", 32'(ovf), 32'(refOvf(av, bv)));
`endif

        @(negedge clk);
        checkOutput("done_pulse_width", 32'(done), 32'd0);
        checkOutput("busy_after", 32'(busy), 32'd0);
        repeat (2) begin
            @(negedge clk);
            checkOutput("no_extra_done", 32'(done), 32'd0);
        end
    endtask

    initial begin
        logic [W-1:0] expA;
        logic [W-1:0] expB;
        int           cyc;
        int           lastDone;
        int           ops;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_diff", 32'(diff), 32'd0);
        checkOutput("reset_borrow", 32'(borrow), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        rst = 1'b0;

        $display("[TB] directed operations");
        applyStimulus(8'h5A, 8'h23, 1'b0);
        applyStimulus(8'h00, 8'h01, 1'b0);
        applyStimulus(8'h80, 8'h01, 1'b0);
        applyStimulus(8'h80, 8'h80, 1'b0);
        applyStimulus(8'h7F, 8'hFF, 1'b0);
        applyStimulus(8'h10, 8'h01, 1'b1);

        $display("[TB] reset in the middle of an operation");
        @(negedge clk);
        a     = 8'h5A;
        b     = 8'h23;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("abort_busy_before", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        checkOutput("abort_diff", 32'(diff), 32'd0);
        checkOutput("abort_borrow", 32'(borrow), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_idle_busy", 32'(busy), 32'd0);
        checkOutput("abort_idle_done", 32'(done), 32'd0);
        applyStimulus(8'h03, 8'h05, 1'b0);

        $display("[TB] random operations");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(W'($urandom), W'($urandom), 1'b0);
        end

        $display("[TB] back-to-back with start held high");
        @(negedge clk);
        expA  = W'($urandom);
        expB  = W'($urandom);
        a     = expA;
        b     = expB;
        start = 1'b1;
        cyc      = 0;
        lastDone = -1;
        ops      = 0;
        for (int k = 0; k < 200 && ops < 4; k++) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                checkOutput("b2b_diff", 32'(diff), 32'(refDiff(expA, expB)));
                checkOutput("b2b_borrow", 32'(borrow), 32'(expA < expB));
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
                checkOutput("b2b_ovf", 32'(ovf), 32'(refOvf(expA, expB)));
`endif
                if (lastDone >= 0) checkOutput("b2b_period", 32'(cyc - lastDone), 32'(W + 2));
                lastDone = cyc;
                ops++;
                expA = W'($urandom);
                expB = W'($urandom);
                a    = expA;
                b    = expB;
            end
        end
        start = 1'b0;
        checkOutput("b2b_ops", 32'(ops), 32'd4);
        repeat (W + 4) @(negedge clk);
        checkOutput("b2b_final_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
